sensor_scan_sequencer: RTL and testbench

Upstream acquisition stage for the microgreen monitor. It steps an external 4:1 analog mux across the soil, temperature, humidity and light sensors, and reads each channel from an 8-bit serial ADC (CS_N/SCLK/MISO, MSB first). Each result is handed downstream as a (sample, sensor_sel) beat on a valid/ready handshake. The downstream threshold/averaging monitor no longer depends on host-driven sensor_sel sequencing.

---
 rtl/sensor_scan_sequencer_pkg.sv | 37 +++
 rtl/sensor_scan_sequencer_if.sv | 23 ++
 rtl/sensor_scan_sequencer_adc_spi_rx.sv | 64 ++++++
 rtl/sensor_scan_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_sensor_scan_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_scan_sequencer_pkg.sv
// Shared definitions for the microgreen monitor acquisition path: sensor IDs,
// sequencer state encoding, the downstream beat layout and a sizing helper.
package farm_pkg;

  localparam logic [1:0] SENSOR_SOIL  = 2'd0;
  localparam logic [1:0] SENSOR_TEMP  = 2'd1;
  localparam logic [1:0] SENSOR_HUMID = 2'd2;
  localparam logic [1:0] SENSOR_LIGHT = 2'd3;
  localparam int         SENSOR_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CONV,
    ST_OUT,
    ST_GAP
  } seq_state_t;

  // One downstream beat: which sensor, and its 8-bit reading.
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } sample_beat_t;

  // Largest of four timing parameters; sizes the shared phase counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sensor_scan_sequencer_if.sv
// Valid/ready sample bus between the scan sequencer and the threshold monitor.
interface sensor_scan_sequencer_if;

  logic [7:0] sample_data;
  logic [1:0] sample_sel;
  logic       sample_valid;
  logic       sample_ready;

  modport master (
    output sample_data,
    output sample_sel,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_sel,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sensor_scan_sequencer_adc_spi_rx.sv
// Serial ADC reader: generates SCLK from the system clock, counts rising edges
// and shifts MISO in MSB first. A go pulse starts one 8-bit read; done is high
// in the cycle that ends the high phase of the 8th bit.
module adc_spi_rx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       go,
  input  logic       miso,
  output logic       sclk,
  output logic       done,
  output logic [7:0] data
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             half_tc;

  assign half_tc = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done    = half_tc && sclk && (bit_cnt == 4'd8);
  assign data    = shift_reg;

  // Half-period divider, SCLK toggle, rising-edge capture and bit counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      shift_reg <= '0;
    end else if (ena) begin
      if (go) begin
        active  <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        sclk    <= 1'b0;
      end else if (active) begin
        if (half_tc) begin
          div_cnt <= '0;
          if (done) begin
            // End of the last high phase: park SCLK low and stop.
            active <= 1'b0;
            sclk   <= 1'b0;
          end else begin
            sclk <= ~sclk;
            if (!sclk) begin
              shift_reg <= {shift_reg[6:0], miso};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sensor_scan_sequencer.sv
// Acquisition sequencer: steps the 4:1 analog mux over the four sensors, reads
// each one through the serial ADC and presents the result as a valid/ready beat.
module sensor_scan_sequencer
  import farm_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CONV_CYC   = 16,
  parameter int GAP_CYC    = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           adc_miso,
  output logic                           adc_cs_n,
  output logic                           adc_sclk,
  output logic [1:0]                     mux_sel,
  sensor_scan_sequencer_if.master        sample,
  output logic                           busy,
  output logic                           scan_done
);

  localparam int CNT_MAX = max4(SETTLE_CYC, CLK_DIV, CONV_CYC, GAP_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t   state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]   ch, ch_nxt;
  logic [1:0]   mux_q, mux_nxt;
  logic         cs_n_q, cs_n_nxt;
  sample_beat_t beat_q, beat_nxt;
  logic         valid_q, valid_nxt;
  logic         done_q, done_nxt;
  logic         spi_go;
  logic         spi_done;
  logic [7:0]   spi_data;

  adc_spi_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_rx (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .go   (spi_go),
    .miso (adc_miso),
    .sclk (adc_sclk),
    .done (spi_done),
    .data (spi_data)
  );

  assign adc_cs_n            = cs_n_q;
  assign mux_sel             = mux_q;
  assign sample.sample_data  = beat_q.data;
  assign sample.sample_sel   = beat_q.sel;
  assign sample.sample_valid = valid_q;
  assign busy                = (state != ST_IDLE);
  assign scan_done           = done_q;

  // Next-state and next-output decode for the scan sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    mux_nxt   = mux_q;
    cs_n_nxt  = cs_n_q;
    beat_nxt  = beat_q;
    valid_nxt = valid_q;
    done_nxt  = 1'b0;
    spi_go    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start || (continuous && cnt == CNT_W'(GAP_CYC - 1))) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          ch_nxt    = SENSOR_SOIL;
          mux_nxt   = SENSOR_SOIL;
        end else if (continuous) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
          spi_go    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          state_nxt = ST_CONV;
          cs_n_nxt  = 1'b1;
        end
      end
      ST_CONV: begin
        if (cnt == CNT_W'(CONV_CYC - 1)) begin
          state_nxt     = ST_OUT;
          cnt_nxt       = '0;
          beat_nxt.data = spi_data;
          beat_nxt.sel  = ch;
          valid_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_OUT: begin
        // valid is always high here, so ready alone completes the handshake.
        if (sample.sample_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          if (ch == SENSOR_LIGHT) begin
            done_nxt  = 1'b1;
            state_nxt = continuous ? ST_GAP : ST_IDLE;
          end else begin
            ch_nxt    = ch + 2'd1;
            mux_nxt   = ch + 2'd1;
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_GAP: begin
        if (!continuous) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          ch_nxt    = SENSOR_SOIL;
          mux_nxt   = SENSOR_SOIL;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; ena low freezes everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ch      <= SENSOR_SOIL;
      mux_q   <= SENSOR_SOIL;
      cs_n_q  <= 1'b1;
      beat_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ch      <= ch_nxt;
      mux_q   <= mux_nxt;
      cs_n_q  <= cs_n_nxt;
      beat_q  <= beat_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Self-checking bench for sensor_scan_sequencer: behavioural serial ADC keyed
// on mux_sel, beat scoreboard, SCLK timing monitor and per-feature scenarios.
module tb_sensor_scan_sequencer;
  import farm_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int SETTLE_CYC = 8;
  localparam int CONV_CYC   = 16;
  localparam int GAP_CYC    = 64;
  localparam int BEAT_LAT   = 1 + SETTLE_CYC + CLK_DIV + 16 * CLK_DIV + CONV_CYC;
  localparam int SCAN_LAT   = SENSOR_COUNT * BEAT_LAT + 1;

  logic       clk = 1'b0;
  logic       rst, ena, start, continuous, adc_miso;
  logic       adc_cs_n, adc_sclk, busy, scan_done;
  logic [1:0] mux_sel;

  sensor_scan_sequencer_if bus ();

  sensor_scan_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .SETTLE_CYC (SETTLE_CYC),
    .CONV_CYC   (CONV_CYC),
    .GAP_CYC    (GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .continuous (continuous),
    .adc_miso   (adc_miso),
    .adc_cs_n   (adc_cs_n),
    .adc_sclk   (adc_sclk),
    .mux_sel    (mux_sel),
    .sample     (bus),
    .busy       (busy),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  int cycle     = 0;

  always @(posedge clk) cycle++;

  // ---------------- ADC model: byte chosen by mux_sel at CS_N fall --------
  logic [7:0] adc_val [4];
  logic [7:0] cur_byte = 8'h00;
  int         bit_idx = 0;
  logic       a_prev_cs = 1'b1;
  logic       a_prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (a_prev_cs === 1'b1 && adc_cs_n === 1'b0) begin
      cur_byte = adc_val[mux_sel];
      bit_idx  = 0;
    end else if (adc_cs_n === 1'b0 && a_prev_sclk === 1'b1 && adc_sclk === 1'b0) begin
      bit_idx++;
    end
    adc_miso    = (bit_idx < 8) ? cur_byte[7 - bit_idx] : 1'b0;
    a_prev_cs   = adc_cs_n;
    a_prev_sclk = adc_sclk;
  end

  // ---------------- Scoreboard: compare each accepted beat ----------------
  sample_beat_t exp_q [$];
  sample_beat_t exp_b;

  always @(negedge clk) begin
    if (rst === 1'b0 && ena === 1'b1 && bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got sel=%0d data=%h, expected no beat",
                 bus.sample_sel, bus.sample_data);
      end else begin
        exp_b = exp_q.pop_front();
        if ({bus.sample_sel, bus.sample_data} !== exp_b) begin
          fails++;
          $display("FAIL beat_value: got sel=%0d data=%h, expected sel=%0d data=%h",
                   bus.sample_sel, bus.sample_data, exp_b.sel, exp_b.data);
        end
      end
    end
  end

  // ---------------- SCLK / CS_N / mux monitor ------------------------------
  logic m_cs = 1'b1, m_sclk = 1'b0, m_ena = 1'b1;
  logic [1:0] m_mux = 2'd0;
  bit   win_ok = 1'b0, first_ph = 1'b0;
  int   ph_len = 0, rises = 0;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      win_ok = 1'b0;
    end else if (m_ena) begin
      if (m_cs === 1'b1 && adc_cs_n === 1'b0) begin
        win_ok = 1'b1; rises = 0; ph_len = 1; first_ph = 1'b1;
      end else if (m_cs === 1'b0) begin
        if (win_ok) begin
          tests_run++;
          if (mux_sel !== m_mux) begin
            fails++;
            $display("FAIL mux_change_cs_low: got %0d, expected %0d", mux_sel, m_mux);
          end
        end
        if (adc_sclk !== m_sclk) begin
          if (win_ok && !first_ph) begin
            tests_run++;
            if (ph_len != CLK_DIV) begin
              fails++;
              $display("FAIL sclk_phase_len: got %0d, expected %0d (level %0b)", ph_len, CLK_DIV, m_sclk);
            end
          end
          first_ph = 1'b0;
          if (adc_sclk === 1'b1) rises++;
          ph_len = 1;
        end else begin
          ph_len++;
        end
        if (adc_cs_n === 1'b1 && win_ok) begin
          tests_run++;
          if (rises != 8 || adc_sclk !== 1'b0) begin
            fails++;
            $display("FAIL cs_window: got %0d rises sclk=%0b, expected 8 rises sclk=0", rises, adc_sclk);
          end
          win_ok = 1'b0;
        end
      end
    end
    m_cs   = adc_cs_n;
    m_sclk = adc_sclk;
    m_mux  = mux_sel;
    m_ena  = ena;
  end

  // ---------------- Helpers (stimulus and bounded waits) ------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_scan();
    for (int i = 0; i < SENSOR_COUNT; i++)
      exp_q.push_back(sample_beat_t'{sel: 2'(i), data: adc_val[i]});
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin tick(1); n++; end while (bus.sample_valid !== 1'b1 && n < budget);
    if (bus.sample_valid !== 1'b1) begin
      tests_run++; fails++;
      $display("FAIL timeout_valid: got no beat, expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin tick(1); n++; end while (scan_done !== 1'b1 && n < budget);
    if (scan_done !== 1'b1) begin
      tests_run++; fails++;
      $display("FAIL timeout_scan_done: got none, expected within %0d cycles", budget);
    end
  endtask

  task automatic check_queue_empty(input string tag);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_beats_missing: got %0d pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- Scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    tests_run++;
    if ({adc_cs_n, adc_sclk, mux_sel, bus.sample_data, bus.sample_sel, bus.sample_valid, busy, scan_done}
        !== {1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got cs_n=%b sclk=%b mux=%0d data=%h sel=%0d valid=%b busy=%b done=%b, expected 1 0 0 00 0 0 0 0",
               adc_cs_n, adc_sclk, mux_sel, bus.sample_data, bus.sample_sel, bus.sample_valid, busy, scan_done);
    end
    rst = 1'b0;
    tick(5);
    tests_run++;
    if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: got busy=%b cs_n=%b, expected 0 1", busy, adc_cs_n);
    end
  endtask

  task automatic test_single_scan();
    int c0, n_done;
    push_scan();
    c0 = cycle;
    pulse_start();
    wait_valid(300);
    tests_run++;
    if (cycle - c0 != BEAT_LAT) begin
      fails++;
      $display("FAIL first_beat_latency: got %0d, expected %0d", cycle - c0, BEAT_LAT);
    end
    wait_done(1000);
    tests_run++;
    if (cycle - c0 != SCAN_LAT) begin
      fails++;
      $display("FAIL scan_latency: got %0d, expected %0d", cycle - c0, SCAN_LAT);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_after_done: got %b, expected 0", busy);
    end
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (scan_done === 1'b1) n_done++;
    end
    tests_run++;
    if (n_done != 0) begin
      fails++;
      $display("FAIL scan_done_width: got %0d extra cycles high, expected 0", n_done);
    end
    check_queue_empty("single_scan");
  endtask

  task automatic test_backpressure();
    push_scan();
    pulse_start();
    wait_valid(300);
    tick(1);
    bus.sample_ready = 1'b0;
    wait_valid(300);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if ({bus.sample_valid, bus.sample_sel, bus.sample_data, adc_cs_n, adc_sclk, mux_sel}
          !== {1'b1, 2'd1, 8'h3C, 1'b1, 1'b0, 2'd1}) begin
        fails++;
        $display("FAIL stall_hold: got valid=%b sel=%0d data=%h cs_n=%b sclk=%b mux=%0d, expected 1 1 3c 1 0 1",
                 bus.sample_valid, bus.sample_sel, bus.sample_data, adc_cs_n, adc_sclk, mux_sel);
      end
      tick(1);
    end
    bus.sample_ready = 1'b1;
    tick(1);
    tests_run++;
    if (mux_sel !== 2'd2 || bus.sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL release_step: got mux=%0d valid=%b, expected 2 0", mux_sel, bus.sample_valid);
    end
    wait_done(1000);
    check_queue_empty("backpressure");
  endtask

  task automatic test_reset_mid_shift();
    int n = 0, r = 0;
    logic prev;
    pulse_start();
    prev = adc_sclk;
    while (r < 3 && n < 300) begin
      tick(1); n++;
      if (adc_sclk === 1'b1 && prev === 1'b0) r++;
      prev = adc_sclk;
    end
    if (r < 3) begin
      tests_run++; fails++;
      $display("FAIL timeout_sclk_edges: got %0d rises, expected 3", r);
    end
    rst = 1'b1;
    tick(1);
    tests_run++;
    if ({adc_cs_n, adc_sclk, busy, bus.sample_valid} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_mid_shift: got cs_n=%b sclk=%b busy=%b valid=%b, expected 1 0 0 0",
               adc_cs_n, adc_sclk, busy, bus.sample_valid);
    end
    rst = 1'b0;
    push_scan();
    pulse_start();
    wait_valid(300);
    tests_run++;
    if (bus.sample_data !== 8'hA5 || bus.sample_sel !== 2'd0) begin
      fails++;
      $display("FAIL restart_first_beat: got sel=%0d data=%h, expected 0 a5", bus.sample_sel, bus.sample_data);
    end
    wait_done(1000);
    check_queue_empty("reset_mid_shift");
  endtask

  task automatic test_ena_freeze();
    int c0, n = 0, r = 0;
    logic prev, lvl;
    push_scan();
    c0 = cycle;
    pulse_start();
    prev = adc_sclk;
    while (r < 2 && n < 1000) begin
      tick(1); n++;
      if (mux_sel === 2'd2 && adc_cs_n === 1'b0 && adc_sclk === 1'b1 && prev === 1'b0) r++;
      prev = adc_sclk;
    end
    if (r < 2) begin
      tests_run++; fails++;
      $display("FAIL timeout_sel2_shift: got %0d rises, expected 2", r);
    end
    ena = 1'b0;
    lvl = adc_sclk;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      tests_run++;
      if (adc_sclk !== lvl || adc_cs_n !== 1'b0) begin
        fails++;
        $display("FAIL ena_freeze: got sclk=%b cs_n=%b, expected %b 0", adc_sclk, adc_cs_n, lvl);
      end
    end
    ena = 1'b1;
    wait_done(1000);
    tests_run++;
    if (cycle - c0 != SCAN_LAT + 10) begin
      fails++;
      $display("FAIL ena_latency: got %0d, expected %0d", cycle - c0, SCAN_LAT + 10);
    end
    check_queue_empty("ena_freeze");
  endtask

  task automatic test_continuous();
    int t, n = 0, cs_low = 0, busy_hi = 0;
    adc_val = '{8'h1E, 8'h6B, 8'hC4, 8'h07};
    continuous = 1'b1;
    push_scan();
    push_scan();
    pulse_start();
    wait_done(1000);
    t = cycle;
    tests_run++;
    if (mux_sel !== SENSOR_LIGHT || busy !== 1'b1) begin
      fails++;
      $display("FAIL gap_entry: got mux=%0d busy=%b, expected 3 1", mux_sel, busy);
    end
    while (mux_sel !== SENSOR_SOIL && n < 200) begin
      tick(1); n++;
    end
    tests_run++;
    if (cycle - t != GAP_CYC) begin
      fails++;
      $display("FAIL gap_length: got %0d, expected %0d", cycle - t, GAP_CYC);
    end
    wait_done(1000);
    tick(10);
    continuous = 1'b0;
    tick(1);
    tests_run++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL gap_abort: got busy=%b, expected 0", busy);
    end
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (adc_cs_n !== 1'b1) cs_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    tests_run++;
    if (cs_low != 0 || busy_hi != 0) begin
      fails++;
      $display("FAIL idle_after_abort: got cs_low=%0d busy_hi=%0d, expected 0 0", cs_low, busy_hi);
    end
    check_queue_empty("continuous");
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; continuous = 1'b0;
    adc_miso = 1'b0; bus.sample_ready = 1'b1;
    adc_val = '{8'hA5, 8'h3C, 8'h81, 8'hFF};
    test_reset();
    test_single_scan();
    test_backpressure();
    test_reset_mid_shift();
    test_ena_freeze();
    test_continuous();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1);
  end

endmodule
